// File: rtl/dmem_wait_responder_if.sv
// dmem_wait_responder_if: SRAM-style data-port bundle between core (master) and data memory (slave)
interface dmem_wait_responder_if #(parameter int ADDR_W = 7);
  logic CEN;
  logic WEN;
  logic OEN;
  logic [ADDR_W-1:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic stall;
  logic busy;
  modport master(output CEN, WEN, OEN, A, D, input Q, stall, busy);
  modport slave(input CEN, WEN, OEN, A, D, output Q, stall, busy);
endinterface

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: word data memory that answers each access after RD_LAT/WR_LAT cycles and stalls the core meanwhile
module dmem_wait_responder #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input logic clk,
  input logic rst,
  dmem_wait_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
  logic [31:0] mem [2**ADDR_W];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d, q_q, q_d;
  logic wen_q, wen_d;
  logic done_entry;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wen_d = wen_q;
    case (state_q)
      IDLE: if (!bus.CEN) begin
        addr_d = bus.A;
        data_d = bus.D;
        wen_d = bus.WEN;
        cnt_d = bus.WEN ? RD_CNT : WR_CNT;
        state_d = cnt_d != 4'd0 ? WAIT : DONE;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    done_entry = state_d == DONE && state_q != DONE;
    q_d = done_entry && wen_d ? mem[addr_d] : q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q <= 1'b0;
      q_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q <= wen_d;
      q_q <= q_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && done_entry && !wen_d) mem[addr_d] <= data_d;
  end
  assign bus.stall = !rst && (state_q == WAIT || (state_q == IDLE && !bus.CEN));
  assign bus.busy = !rst && state_q != IDLE;
  assign bus.Q = bus.OEN ? 32'h0 : q_q;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: vector-driven check of the wait-state data memory at two latency settings
module tb_dmem_wait_responder;
  typedef struct packed {
    logic rst;
    logic cen;
    logic wen;
    logic oen;
    logic [6:0] a;
    logic [31:0] d;
    logic stall;
    logic busy;
    logic [31:0] q;
  } vec_t;
  logic clk = 1'b1;
  logic rst_a, rst_b;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[$];
  dmem_wait_responder_if #(.ADDR_W(7)) bus_a();
  dmem_wait_responder_if #(.ADDR_W(7)) bus_b();
  dmem_wait_responder #(.ADDR_W(7), .RD_LAT(2), .WR_LAT(1)) u_a(.clk(clk), .rst(rst_a), .bus(bus_a));
  dmem_wait_responder #(.ADDR_W(7), .RD_LAT(1), .WR_LAT(3)) u_b(.clk(clk), .rst(rst_b), .bus(bus_b));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rst, cen, wen, oen, input logic [6:0] a, input logic [31:0] d,
                              input logic stall, busy, input logic [31:0] q);
    vec_t v;
    v.rst = rst;
    v.cen = cen;
    v.wen = wen;
    v.oen = oen;
    v.a = a;
    v.d = d;
    v.stall = stall;
    v.busy = busy;
    v.q = q;
    return v;
  endfunction
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input bit on_b, input string tag);
    if (on_b) begin
      rst_b = v.rst;
      bus_b.CEN = v.cen;
      bus_b.WEN = v.wen;
      bus_b.OEN = v.oen;
      bus_b.A = v.a;
      bus_b.D = v.d;
    end else begin
      rst_a = v.rst;
      bus_a.CEN = v.cen;
      bus_a.WEN = v.wen;
      bus_a.OEN = v.oen;
      bus_a.A = v.a;
      bus_a.D = v.d;
    end
    @(negedge clk);
    if (on_b) begin
      cmp({tag, " stall"}, 32'(bus_b.stall), 32'(v.stall));
      cmp({tag, " busy"}, 32'(bus_b.busy), 32'(v.busy));
      cmp({tag, " Q"}, bus_b.Q, v.q);
    end else begin
      cmp({tag, " stall"}, 32'(bus_a.stall), 32'(v.stall));
      cmp({tag, " busy"}, 32'(bus_a.busy), 32'(v.busy));
      cmp({tag, " Q"}, bus_a.Q, v.q);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_b = 1'b1;
    bus_b.CEN = 1'b1;
    bus_b.WEN = 1'b1;
    bus_b.OEN = 1'b0;
    bus_b.A = '0;
    bus_b.D = '0;
    //         rst  cen  wen  oen  a      d              stall busy q
    tv.push_back(mk(1, 0, 1, 1, 7'h00, 32'h0,        0, 0, 32'h0));
    tv.push_back(mk(1, 0, 1, 0, 7'h00, 32'h0,        0, 0, 32'h0));
    tv.push_back(mk(0, 0, 0, 0, 7'h05, 32'hDEADBEEF, 1, 0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 7'h00, 32'h0,        0, 1, 32'h0));
    tv.push_back(mk(0, 0, 1, 0, 7'h05, 32'h0,        1, 0, 32'h0));
    tv.push_back(mk(0, 0, 1, 0, 7'h05, 32'h0,        1, 1, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 7'h05, 32'h0,        0, 1, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 0, 0, 7'h10, 32'h1234,     1, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 1, 1, 0, 7'h10, 32'h1234,     0, 1, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 1, 0, 7'h10, 32'h0,        1, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 1, 0, 7'h10, 32'h0,        1, 1, 32'hDEADBEEF));
    tv.push_back(mk(0, 1, 1, 0, 7'h10, 32'h0,        0, 1, 32'h00001234));
    tv.push_back(mk(0, 1, 1, 0, 7'h10, 32'h0,        0, 0, 32'h00001234));
    tv.push_back(mk(0, 0, 0, 0, 7'h7F, 32'hA5A5A5A5, 1, 0, 32'h00001234));
    tv.push_back(mk(0, 1, 1, 0, 7'h7F, 32'h0,        0, 1, 32'h00001234));
    tv.push_back(mk(0, 0, 1, 0, 7'h05, 32'h0,        1, 0, 32'h00001234));
    tv.push_back(mk(0, 1, 0, 0, 7'h7F, 32'h0,        1, 1, 32'h00001234));
    tv.push_back(mk(0, 1, 0, 0, 7'h7F, 32'h0,        0, 1, 32'hDEADBEEF));
    tv.push_back(mk(0, 1, 1, 0, 7'h7F, 32'h0,        0, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 1, 0, 7'h10, 32'h0,        1, 0, 32'hDEADBEEF));
    tv.push_back(mk(1, 0, 1, 0, 7'h10, 32'h0,        0, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 1, 1, 0, 7'h10, 32'h0,        0, 0, 32'h0));
    tv.push_back(mk(0, 0, 0, 0, 7'h33, 32'hCAFEF00D, 1, 0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 7'h33, 32'h0,        0, 1, 32'h0));
    tv.push_back(mk(0, 0, 1, 0, 7'h33, 32'h0,        1, 0, 32'h0));
    tv.push_back(mk(0, 0, 1, 0, 7'h33, 32'h0,        1, 1, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 7'h33, 32'h0,        0, 1, 32'hCAFEF00D));
    tv.push_back(mk(0, 1, 1, 1, 7'h33, 32'h0,        0, 0, 32'h0));
    tv.push_back(mk(0, 0, 0, 0, 7'h33, 32'h0,        1, 0, 32'hCAFEF00D));
    tv.push_back(mk(0, 1, 1, 0, 7'h33, 32'h0,        0, 1, 32'hCAFEF00D));
    tv.push_back(mk(0, 1, 1, 1, 7'h33, 32'h0,        0, 0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 7'h33, 32'h0,        0, 0, 32'hCAFEF00D));
    tv.push_back(mk(0, 0, 1, 0, 7'h33, 32'h0,        1, 0, 32'hCAFEF00D));
    tv.push_back(mk(0, 0, 1, 0, 7'h33, 32'h0,        1, 1, 32'hCAFEF00D));
    tv.push_back(mk(0, 1, 1, 0, 7'h33, 32'h0,        0, 1, 32'h0));
    foreach (tv[i]) step(tv[i], 1'b0, $sformatf("a%0d", i));
    rst_a = 1'b1;
    bus_a.CEN = 1'b1;
    step(mk(0, 0, 0, 0, 7'h20, 32'h11112222, 1, 0, 32'h0), 1'b1, "b_wr_accept");
    step(mk(0, 0, 0, 0, 7'h20, 32'h11112222, 1, 1, 32'h0), 1'b1, "b_wr_wait1");
    step(mk(0, 0, 0, 0, 7'h20, 32'h11112222, 1, 1, 32'h0), 1'b1, "b_wr_wait2");
    step(mk(0, 1, 1, 0, 7'h20, 32'h0,        0, 1, 32'h0), 1'b1, "b_wr_done");
    step(mk(0, 0, 1, 0, 7'h20, 32'h0,        1, 0, 32'h0), 1'b1, "b_rd_accept");
    step(mk(0, 1, 1, 0, 7'h20, 32'h0,        0, 1, 32'h11112222), 1'b1, "b_rd_done");
    step(mk(0, 0, 0, 0, 7'h20, 32'hFFFF0000, 1, 0, 32'h11112222), 1'b1, "b_wr2_accept");
    step(mk(1, 0, 0, 0, 7'h20, 32'hFFFF0000, 0, 0, 32'h11112222), 1'b1, "b_rst_in_wait");
    step(mk(0, 1, 1, 0, 7'h20, 32'h0,        0, 0, 32'h0), 1'b1, "b_after_rst");
    step(mk(0, 0, 1, 0, 7'h20, 32'h0,        1, 0, 32'h0), 1'b1, "b_rd2_accept");
    step(mk(0, 1, 1, 0, 7'h20, 32'h0,        0, 1, 32'h11112222), 1'b1, "b_rd2_done");
    step(mk(0, 1, 1, 0, 7'h20, 32'h0,        0, 0, 32'h11112222), 1'b1, "b_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder for the single-cycle MIPS core's SRAM-style data port (CEN/WEN/OEN/A/D/Q).
- Holds a 2^ADDR_W x 32 word array and services each access after a parameterised latency.
- Drives stall so the core freezes PC and register writeback until the access completes.
- Replaces the zero-latency SRAM model on the next multi-cycle/stall-capable core revision.

Parameters:
ADDR_W, 7, word-address width; array depth 2^ADDR_W (128 words)
RD_LAT, 2, read latency in cycles from request acceptance to Q valid; legal 1..15
WR_LAT, 1, write latency in cycles from request acceptance to commit; legal 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
CEN  input  1  chip enable, active low; 0 = access requested
WEN  input  1  0 = write, 1 = read; sampled with CEN
OEN  input  1  output enable, active low; 1 forces Q to 0
A  input  ADDR_W  word address
D  input  32  write data
Q  output  32  read data
stall  output  1  1 = access in progress, core must hold CEN/WEN/A/D and not advance
busy  output  1  1 when FSM not IDLE (registered status)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cnt=0, q_reg=0, latched addr/data/wen=0. Array contents are not cleared. While rst=1, stall=0 and busy=0 regardless of CEN.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - stall = ~CEN, combinational, so stall rises in the same cycle as the request.
  - At posedge with CEN=0: latch A, D, WEN; load cnt = (WEN ? RD_LAT : WR_LAT) - 1.
  - Next state is WAIT if the loaded cnt > 0, else DONE.
- WAIT: stall=1. cnt decrements each posedge; when cnt==1 at posedge, go to DONE.
- Entry to DONE (same posedge that moves into DONE):
  - Write: array[addr_l] <= d_l.
  - Read: q_reg <= array[addr_l].
- DONE: stall=0, so the core completes the instruction this cycle. Next posedge returns to IDLE unconditionally.
- Cycle counts: a read occupies RD_LAT+1 cycles with stall high for RD_LAT cycles. A write occupies WR_LAT+1 cycles with stall high for WR_LAT cycles.
- Back-to-back accesses: a request presented in the cycle after DONE is seen in IDLE and stalls normally; no request is ever accepted in DONE.
- Request signals are latched at acceptance. Changes to CEN/WEN/A/D during WAIT/DONE are ignored. CEN rising mid-access does not abort the access.
- Q = OEN ? 32'h0 : q_reg. q_reg holds the last read value through writes and idle cycles; it updates only on read completion.
- Read-after-write to the same address returns the new data, because the write is committed on entry to DONE, before any later acceptance.
- Reset mid-access returns the FSM to IDLE immediately:
  - A pending write is discarded (array unchanged).
  - A pending read leaves q_reg=0.
- busy = (state != IDLE).
- Address is a full ADDR_W bits; no out-of-range case.
- Array reads/writes are word-granular only; no byte enables.

Test Plan:
1. Reset, then write A=7'h05 D=32'hDEADBEEF, WR_LAT=1 -> stall high 1 cycle (request cycle), DONE next cycle with stall=0; array[5]=32'hDEADBEEF.
2. Read A=7'h05 with RD_LAT=2, OEN=0 -> stall high cycles 0-1, Q=32'hDEADBEEF in cycle 2 with stall=0; busy=1 in cycles 1-2.
3. Write A=7'h10 D=32'h1234 immediately followed by a read of A=7'h10 -> read returns 32'h00001234; no cycle with stall=0 in IDLE while CEN=0.
4. Read in flight with CEN driven high and A changed to 7'h7F during WAIT -> completion still returns the data at the originally latched address.
5. rst asserted in WAIT of a write to A=7'h20 D=32'hFFFF0000 -> next cycle state IDLE, stall=0, Q=0; a later read of 7'h20 returns the prior contents.
6. Read completes with Q=32'hCAFEF00D, then OEN=1 -> Q=0; OEN=0 -> Q=32'hCAFEF00D, unchanged by an intervening write.
